// File: rtl/commit_trace_buf.sv
// Purpose : buffers retired-instruction records (instr, pre_pc, pc) from write-back for a trace consumer.
// Latency : a commit is visible at trace_data/trace_valid one cycle after its rising edge.
// Backpr. : trace_ready=0 holds the head entry; stall_req warns the CPU early; commits arriving when full are dropped and counted.
//
// Ports:
//   clk, rst                 - single clock, asynchronous active-low reset
//   commit, commit_instr,
//   commit_pc, commit_pre_pc - retirement strobe and its record
//   trace_valid/trace_ready  - valid/ready handshake for the head entry
//   trace_data               - head entry {instr[159:128], pre_pc[127:64], pc[63:0]}
//   stall_req                - registered, occupancy >= AFULL_LVL
//   overflow, drop_cnt       - sticky drop flag and saturating drop count
//   retire_cnt               - commits accepted (wraps modulo 2^64)
//   level                    - current occupancy
module commit_trace_buf #(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       commit,
    input  logic [31:0]                commit_instr,
    input  logic [63:0]                commit_pc,
    input  logic [63:0]                commit_pre_pc,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [159:0]               trace_data,
    output logic                       stall_req,
    output logic                       overflow,
    output logic [15:0]                drop_cnt,
    output logic [63:0]                retire_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AFULL_W = (AW+1)'(AFULL_LVL);

    // Record storage is deliberately left out of reset; pointers alone define validity.
    logic [159:0] mem [DEPTH];

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] level_nxt;
    logic        full;
    logic        push;
    logic        pop;
    logic        drop;

    // Same slot index with differing wrap bits means every slot is occupied.
    assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign trace_valid = (level != '0);
    assign pop         = trace_valid && trace_ready;
    // A pop in the same cycle frees a slot, so a commit into a full buffer still lands.
    assign push        = commit && (!full || pop);
    assign drop        = commit && full && !pop;

    // Head entry is read straight from storage; nothing from the commit inputs reaches it combinationally.
    assign trace_data = mem[rd_ptr[AW-1:0]];

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + PTR_ONE;
            2'b01:   level_nxt = level - PTR_ONE;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {commit_instr, commit_pre_pc, commit_pc};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            stall_req  <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            retire_cnt <= '0;
        end else begin
            if (push) begin
                // Natural binary increment wraps the index and toggles the wrap bit together.
                wr_ptr     <= wr_ptr + PTR_ONE;
                retire_cnt <= retire_cnt + 64'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level <= level_nxt;
            // Registered from the next level so stall_req moves on the same edge as level.
            stall_req <= (level_nxt >= AFULL_W);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_buf.sv
// Purpose : directed and random checks of commit_trace_buf against a queue-based reference model.
// Latency : one cycle per step; outputs sampled 1 time unit after the rising edge.
// Backpr. : trace_ready driven per step; held head data is compared across stalled cycles.
module tb_commit_trace_buf;

    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         commit;
    logic [31:0]  commit_instr;
    logic [63:0]  commit_pc;
    logic [63:0]  commit_pre_pc;
    logic         trace_valid;
    logic         trace_ready;
    logic [159:0] trace_data;
    logic         stall_req;
    logic         overflow;
    logic [15:0]  drop_cnt;
    logic [63:0]  retire_cnt;
    logic [3:0]   level;

    always #5 clk = ~clk;

    commit_trace_buf #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
        .clk           (clk),
        .rst           (rst),
        .commit        (commit),
        .commit_instr  (commit_instr),
        .commit_pc     (commit_pc),
        .commit_pre_pc (commit_pre_pc),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_data    (trace_data),
        .stall_req     (stall_req),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt),
        .retire_cnt    (retire_cnt),
        .level         (level)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    int           mlevel;
    bit           mover;
    int           mdrop;
    logic [63:0]  mretire;
    logic [159:0] sb [$];
    bit           held_vld;
    logic [159:0] held_dat;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mlevel   = 0;
        mover    = 1'b0;
        mdrop    = 0;
        mretire  = '0;
        held_vld = 1'b0;
        sb.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, " level"},      160'(level),       160'(mlevel));
        chk({tag, " valid"},      160'(trace_valid), 160'(mlevel != 0));
        chk({tag, " stall_req"},  160'(stall_req),   160'(mlevel >= AFULL));
        chk({tag, " overflow"},   160'(overflow),    160'(mover));
        chk({tag, " drop_cnt"},   160'(drop_cnt),    160'(mdrop));
        chk({tag, " retire_cnt"}, 160'(retire_cnt),  160'(mretire));
    endtask

    // One clock step: drive inputs, check the head entry on pops, advance the model, check state after the edge.
    task automatic cycle(input bit c, input logic [31:0] i, input logic [63:0] p,
                         input logic [63:0] pp, input bit r, input string tag);
        bit           pop;
        bit           push;
        bit           drop;
        logic [159:0] exp;
        commit        = c;
        commit_instr  = i;
        commit_pc     = p;
        commit_pre_pc = pp;
        trace_ready   = r;
        if (held_vld) chk({tag, " hold data"}, trace_data, held_dat);
        pop = (mlevel != 0) && r;
        if (pop) begin
            exp = sb.pop_front();
            chk({tag, " head data"}, trace_data, exp);
        end
        held_vld = (mlevel != 0) && !r;
        held_dat = trace_data;
        push = c && ((mlevel < DEPTH) || pop);
        drop = c && (mlevel == DEPTH) && !pop;
        if (push) begin
            sb.push_back({i, pp, p});
            mretire = mretire + 64'd1;
        end
        mlevel = mlevel + int'(push) - int'(pop);
        if (drop) begin
            mover = 1'b1;
            if (mdrop != 65535) mdrop++;
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        rst           = 1'b0;
        commit        = 1'b1;
        commit_instr  = 32'hDEADBEEF;
        commit_pc     = 64'h1;
        commit_pre_pc = 64'h2;
        trace_ready   = 1'b0;
        model_reset();

        // Reset state before any clock, then a commit held high across a reset edge must be ignored.
        #1;
        check_state("reset async");
        @(posedge clk);
        #1;
        check_state("reset edge commit ignored");
        rst = 1'b1;

        // Single pass-through
        cycle(1'b1, 32'h00000013, 64'h80000000, 64'h80000004, 1'b1, "pass push");
        chk("pass valid", 160'(trace_valid), 160'(1));
        chk("pass data", trace_data, {32'h00000013, 64'h80000004, 64'h80000000});
        cycle(1'b0, 32'h0, 64'h0, 64'h0, 1'b1, "pass pop");
        chk("pass valid after", 160'(trace_valid), 160'(0));
        chk("pass retire", 160'(retire_cnt), 160'(1));

        // Fill and overflow with the consumer stalled
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 32'(k), 64'h1000 + 64'(4 * k), 64'h1004 + 64'(4 * k), 1'b0, "fill");
        end
        chk("fill level", 160'(level), 160'(8));
        chk("fill stall", 160'(stall_req), 160'(1));
        chk("fill overflow", 160'(overflow), 160'(1));
        chk("fill drop_cnt", 160'(drop_cnt), 160'(2));

        // Full with simultaneous push and pop, crossing the pointer wrap
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h100 + 32'(k), 64'h2000 + 64'(4 * k), 64'h2004 + 64'(4 * k), 1'b1, "full pushpop");
        end
        chk("full pushpop level", 160'(level), 160'(8));
        chk("full pushpop drop_cnt", 160'(drop_cnt), 160'(2));

        // Drain: remaining 0x100C..0x101C then the 0x2000 group, in order
        repeat (9) cycle(1'b0, 32'h0, 64'h0, 64'h0, 1'b1, "drain");
        chk("drain level", 160'(level), 160'(0));

        // Back-pressure with ready toggling and random commits
        for (int n = 0; n < 60; n++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, {$urandom, $urandom},
                  1'(n % 2), "random");
        end
        repeat (10) cycle(1'b0, 32'h0, 64'h0, 64'h0, 1'b1, "random drain");

        // Reset mid-operation with five entries buffered
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 32'h300 + 32'(k), 64'h3000 + 64'(4 * k), 64'h3004 + 64'(4 * k), 1'b0, "prefill");
        end
        chk("prefill level", 160'(level), 160'(5));
        rst = 1'b0;
        #1;
        chk("midrst level", 160'(level), 160'(0));
        chk("midrst valid", 160'(trace_valid), 160'(0));
        chk("midrst stall", 160'(stall_req), 160'(0));
        chk("midrst overflow", 160'(overflow), 160'(0));
        chk("midrst retire", 160'(retire_cnt), 160'(0));
        chk("midrst drop_cnt", 160'(drop_cnt), 160'(0));
        model_reset();
        #1;
        rst = 1'b1;
        cycle(1'b1, 32'h0000ABCD, 64'h4000, 64'h4004, 1'b0, "post reset push");
        chk("post reset level", 160'(level), 160'(1));
        chk("post reset data", trace_data, {32'h0000ABCD, 64'h4004, 64'h4000});
        cycle(1'b0, 32'h0, 64'h0, 64'h0, 1'b1, "post reset pop");
        chk("post reset empty", 160'(trace_valid), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
